// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I-subset control path.
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_BRANCH = 3'd6,
    S_TRAP   = 3'd7
  } state_e;

  typedef enum logic [2:0] {
    C_R       = 3'd0,
    C_I       = 3'd1,
    C_U       = 3'd2,
    C_LOAD    = 3'd3,
    C_STORE   = 3'd4,
    C_BRANCH  = 3'd5,
    C_ILLEGAL = 3'd6
  } iclass_e;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_SRL  = 3'b010;
  localparam logic [2:0] ALU_SLTU = 3'b011;
  localparam logic [2:0] ALU_SUB  = 3'b100;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_SRL  = 3'b101;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_W    = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic       ADDR_PC    = 1'b0;
  localparam logic       ADDR_ALU   = 1'b1;
  localparam logic [1:0] SRCA_PC    = 2'd0;
  localparam logic [1:0] SRCA_OLDPC = 2'd1;
  localparam logic [1:0] SRCA_RS1   = 2'd2;
  localparam logic [1:0] SRCB_RS2   = 2'd0;
  localparam logic [1:0] SRCB_IMM   = 2'd1;
  localparam logic [1:0] SRCB_FOUR  = 2'd2;
  localparam logic [1:0] WD_ALU     = 2'd0;
  localparam logic [1:0] WD_MEM     = 2'd1;
  localparam logic [1:0] WD_UIMM    = 2'd2;

  localparam logic CAUSE_ILLEGAL = 1'b0;
  localparam logic CAUSE_BUS     = 1'b1;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction classifier: class, ALU operation and branch polarity.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [6:0] op,
  input  logic [2:0] f3,
  input  logic [6:0] f7,
  output iclass_e    iclass,
  output logic [2:0] alu_op,
  output logic       br_on_zero
);

  // Opcode/funct classification; any unlisted encoding falls through to illegal.
  always_comb begin
    iclass     = C_ILLEGAL;
    alu_op     = ALU_ADD;
    br_on_zero = 1'b1;
    case (op)
      OP_R: begin
        iclass = C_R;
        case ({f7, f3})
          {F7_BASE, F3_ADD}:  alu_op = ALU_ADD;
          {F7_BASE, F3_OR}:   alu_op = ALU_OR;
          {F7_BASE, F3_SRL}:  alu_op = ALU_SRL;
          {F7_BASE, F3_SLTU}: alu_op = ALU_SLTU;
          {F7_ALT,  F3_ADD}:  alu_op = ALU_SUB;
          default:            iclass = C_ILLEGAL;
        endcase
      end
      OP_IMM: begin
        if (f3 == F3_ADD) iclass = C_I;
        else              iclass = C_ILLEGAL;
      end
      OP_LUI: iclass = C_U;
      OP_LOAD: begin
        if (f3 == F3_W) iclass = C_LOAD;
        else            iclass = C_ILLEGAL;
      end
      OP_STORE: begin
        if (f3 == F3_W) iclass = C_STORE;
        else            iclass = C_ILLEGAL;
      end
      OP_BRANCH: begin
        alu_op = ALU_SUB;
        if (f3 == F3_BEQ) begin
          iclass     = C_BRANCH;
          br_on_zero = 1'b1;
        end else if (f3 == F3_BNE) begin
          iclass     = C_BRANCH;
          br_on_zero = 1'b0;
        end else begin
          iclass = C_ILLEGAL;
        end
      end
      default: iclass = C_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: sequences fetch/decode/execute/memory/writeback,
// drives datapath selects and enables, and traps on illegal opcodes or bus timeout.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] cmd_op,
  input  logic [2:0] cmd_f3,
  input  logic [6:0] cmd_f7,
  input  logic       alu_zero,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       mem_we,
  output logic       addr_src,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic       reg_write,
  output logic [1:0] wd_src,
  output logic       instr_done,
  output logic       trap,
  output logic       trap_cause
);

  localparam logic [7:0] TMAX = 8'(TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] tcnt_q, tcnt_d;
  logic       trap_q, trap_d;
  logic       cause_q, cause_d;

  iclass_e    iclass_s;
  logic [2:0] dec_alu_op_s;
  logic       br_on_zero_s;
  logic       timeout_s;

  ctrl_decode u_decode (
    .op         (cmd_op),
    .f3         (cmd_f3),
    .f7         (cmd_f7),
    .iclass     (iclass_s),
    .alu_op     (dec_alu_op_s),
    .br_on_zero (br_on_zero_s)
  );

  assign timeout_s  = (tcnt_q == TMAX);
  assign trap       = trap_q;
  assign trap_cause = cause_q;

  // State, wait counter and trap registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      tcnt_q  <= 8'd0;
      trap_q  <= 1'b0;
      cause_q <= CAUSE_ILLEGAL;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      trap_q  <= trap_d;
      cause_q <= cause_d;
    end
  end

  // Next-state and datapath controls; ack has priority over a same-cycle timeout.
  always_comb begin
    state_d    = state_q;
    cause_d    = cause_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    addr_src   = ADDR_PC;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    alu_op     = ALU_ADD;
    reg_write  = 1'b0;
    wd_src     = WD_ALU;
    instr_done = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem_req   = 1'b1;
        addr_src  = ADDR_PC;
        alu_src_a = SRCA_PC;
        alu_src_b = SRCB_FOUR;
        alu_op    = ALU_ADD;
        if (mem_ack) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = S_DECODE;
        end else if (timeout_s) begin
          state_d = S_TRAP;
          cause_d = CAUSE_BUS;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        case (iclass_s)
          C_ILLEGAL: begin
            state_d = S_TRAP;
            cause_d = CAUSE_ILLEGAL;
          end
          C_U:     state_d = S_WB;
          default: state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        alu_src_a = SRCA_RS1;
        alu_op    = dec_alu_op_s;
        case (iclass_s)
          C_R: begin
            alu_src_b = SRCB_RS2;
            state_d   = S_WB;
          end
          C_I: begin
            alu_src_b = SRCB_IMM;
            state_d   = S_WB;
          end
          C_LOAD, C_STORE: begin
            alu_src_b = SRCB_IMM;
            state_d   = S_MEM;
          end
          C_BRANCH: begin
            alu_src_b = SRCB_RS2;
            if (alu_zero == br_on_zero_s) begin
              state_d = S_BRANCH;
            end else begin
              instr_done = 1'b1;
              state_d    = S_FETCH;
            end
          end
          default: begin
            state_d = S_TRAP;
            cause_d = CAUSE_ILLEGAL;
          end
        endcase
      end
      S_MEM: begin
        mem_req  = 1'b1;
        addr_src = ADDR_ALU;
        mem_we   = (iclass_s == C_STORE);
        if (mem_ack) begin
          if (iclass_s == C_STORE) begin
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (timeout_s) begin
          state_d = S_TRAP;
          cause_d = CAUSE_BUS;
        end else begin
          state_d = S_MEM;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        case (iclass_s)
          C_LOAD:  wd_src = WD_MEM;
          C_U:     wd_src = WD_UIMM;
          default: wd_src = WD_ALU;
        endcase
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_IMM;
        alu_op     = ALU_ADD;
        pc_we      = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_IDLE;
    endcase
  end

  // Wait counter: restarts on each new request, counts unacknowledged request cycles.
  always_comb begin
    trap_d = trap_q | (state_d == S_TRAP);
    if ((state_d != state_q) && ((state_d == S_FETCH) || (state_d == S_MEM))) begin
      tcnt_d = 8'd0;
    end else if (mem_req) begin
      tcnt_d = mem_ack ? 8'd0 : (tcnt_q + 8'd1);
    end else begin
      tcnt_d = tcnt_q;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: random instruction streams with random
// memory latency, plus directed trap, timeout and mid-request reset scenarios.
module tb_multicycle_ctrl;

  localparam int K_ADD = 0, K_OR = 1, K_SRL = 2, K_SLTU = 3, K_SUB = 4, K_ADDI = 5;
  localparam int K_LUI = 6, K_LW = 7, K_SW = 8, K_BEQ = 9, K_BNE = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] cmd_op = 7'd0;
  logic [2:0] cmd_f3 = 3'd0;
  logic [6:0] cmd_f7 = 7'd0;
  logic       alu_zero = 1'b0;
  logic       mem_ack = 1'b0;
  logic       mem_req, mem_we, addr_src, ir_we, pc_we, reg_write, instr_done, trap, trap_cause;
  logic [1:0] alu_src_a, alu_src_b, wd_src;
  logic [2:0] alu_op;

  always #5 clk = ~clk;

  multicycle_ctrl #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .cmd_op(cmd_op), .cmd_f3(cmd_f3), .cmd_f7(cmd_f7),
    .alu_zero(alu_zero), .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we),
    .addr_src(addr_src), .ir_we(ir_we), .pc_we(pc_we), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write), .wd_src(wd_src),
    .instr_done(instr_done), .trap(trap), .trap_cause(trap_cause)
  );

  typedef struct {
    int cyc; int rw; int wd; int pcw; int mwe; int mreq; int nexec; int eop; int eb; int nbr;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0] p_op[64];
  logic [2:0] p_f3[64];
  logic [6:0] p_f7[64];
  logic       p_zero[64];
  int         p_fw[64];
  int         p_mw[64];
  int         n_prog = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic add_raw(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input int fw, input int mw, input logic z);
    p_op[n_prog] = op; p_f3[n_prog] = f3; p_f7[n_prog] = f7;
    p_fw[n_prog] = fw; p_mw[n_prog] = mw; p_zero[n_prog] = z;
    n_prog++;
  endtask

  // Reference model: expected per-instruction behaviour from the ISA-level rules.
  task automatic add_instr(input int kind, input int fw, input int mw, input logic z);
    logic [6:0] op; logic [2:0] f3; logic [6:0] f7;
    exp_t e;
    bit is_r, is_br, mem, taken;
    f3 = 3'($urandom); f7 = 7'($urandom);
    case (kind)
      K_ADD:  begin op = 7'b0110011; f3 = 3'b000; f7 = 7'b0000000; end
      K_OR:   begin op = 7'b0110011; f3 = 3'b110; f7 = 7'b0000000; end
      K_SRL:  begin op = 7'b0110011; f3 = 3'b101; f7 = 7'b0000000; end
      K_SLTU: begin op = 7'b0110011; f3 = 3'b011; f7 = 7'b0000000; end
      K_SUB:  begin op = 7'b0110011; f3 = 3'b000; f7 = 7'b0100000; end
      K_ADDI: begin op = 7'b0010011; f3 = 3'b000; end
      K_LUI:  op = 7'b0110111;
      K_LW:   begin op = 7'b0000011; f3 = 3'b010; end
      K_SW:   begin op = 7'b0100011; f3 = 3'b010; end
      K_BEQ:  begin op = 7'b1100011; f3 = 3'b000; end
      default: begin op = 7'b1100011; f3 = 3'b001; end
    endcase
    add_raw(op, f3, f7, fw, mw, z);
    is_r  = (kind <= K_SUB);
    is_br = (kind == K_BEQ) || (kind == K_BNE);
    mem   = (kind == K_LW) || (kind == K_SW);
    taken = ((kind == K_BEQ) && z) || ((kind == K_BNE) && !z);
    if (kind == K_LUI)  e.cyc = 3;
    else if (kind == K_LW) e.cyc = 5;
    else if (is_br)     e.cyc = 3 + int'(taken);
    else                e.cyc = 4;
    e.cyc   = e.cyc + fw + (mem ? mw : 0);
    e.rw    = (is_r || kind == K_ADDI || kind == K_LUI || kind == K_LW) ? 1 : 0;
    e.wd    = (kind == K_LW) ? 1 : (kind == K_LUI) ? 2 : 0;
    e.pcw   = 1 + int'(taken);
    e.mwe   = (kind == K_SW) ? mw + 1 : 0;
    e.mreq  = fw + 1 + (mem ? mw + 1 : 0);
    e.nexec = (kind == K_LUI) ? 0 : 1;
    e.eop   = is_r ? kind : (is_br ? 4 : 0);
    e.eb    = (is_r || is_br) ? 0 : 1;
    e.nbr   = int'(taken);
    exp_q.push_back(e);
  endtask

  // Memory / instruction-register responder; ack timing taken from the program table.
  int  fetch_idx = 0, cur_idx = 0, wcnt = 0, wt;
  bit  fetch_acked = 1'b0;
  initial forever begin
    @(posedge clk); #1;
    if (rst) begin
      fetch_idx = 0; wcnt = 0; fetch_acked = 1'b0; mem_ack = 1'b0;
    end else begin
      if (fetch_acked && fetch_idx < 64) begin
        cmd_op = p_op[fetch_idx]; cmd_f3 = p_f3[fetch_idx]; cmd_f7 = p_f7[fetch_idx];
        alu_zero = p_zero[fetch_idx]; cur_idx = fetch_idx; fetch_idx++;
      end
      fetch_acked = 1'b0;
      if (mem_req) begin
        wt = addr_src ? p_mw[cur_idx] : ((fetch_idx < n_prog) ? p_fw[fetch_idx] : 255);
        if (wcnt == wt) begin
          mem_ack = 1'b1; wcnt = 0; fetch_acked = !addr_src;
        end else begin
          mem_ack = 1'b0; wcnt++;
        end
      end else begin
        mem_ack = 1'($urandom_range(0, 1));
        wcnt = 0;
      end
    end
  end

  // Monitor: accumulates observed controls per instruction and scores at retire.
  int a_cyc, a_rw, a_wd, a_pcw, a_mwe, a_mreq, a_nexec, a_eop, a_eb, a_nbr;
  bit started = 1'b0;
  exp_t e_m;
  task automatic clear_acc();
    a_cyc = 0; a_rw = 0; a_wd = 0; a_pcw = 0; a_mwe = 0; a_mreq = 0;
    a_nexec = 0; a_eop = 0; a_eb = 0; a_nbr = 0;
  endtask
  always @(negedge clk) begin
    if (rst) begin
      clear_acc();
      started = 1'b0;
    end else begin
      if (!started && mem_req) started = 1'b1;
      if (started) begin
        a_cyc++;
        if (reg_write) begin a_rw++; a_wd = int'(wd_src); end
        if (pc_we) a_pcw++;
        if (mem_we) a_mwe++;
        if (mem_req) a_mreq++;
        if (alu_src_a == 2'd2) begin a_nexec++; a_eop = int'(alu_op); a_eb = int'(alu_src_b); end
        if (alu_src_a == 2'd1) a_nbr++;
        if (instr_done) begin
          if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_retire: got retire expected none");
          end else begin
            e_m = exp_q.pop_front();
            check("cycles", a_cyc, e_m.cyc);
            check("reg_write_count", a_rw, e_m.rw);
            if (e_m.rw != 0) check("wd_src", a_wd, e_m.wd);
            check("pc_we_count", a_pcw, e_m.pcw);
            check("mem_we_cycles", a_mwe, e_m.mwe);
            check("mem_req_cycles", a_mreq, e_m.mreq);
            check("exec_cycles", a_nexec, e_m.nexec);
            if (e_m.nexec != 0) begin
              check("exec_alu_op", a_eop, e_m.eop);
              check("exec_src_b", a_eb, e_m.eb);
            end
            check("branch_cycles", a_nbr, e_m.nbr);
          end
          clear_acc();
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  logic [6:0] ill_op[7] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1111111, 7'b1100011, 7'b0110011, 7'b0100011};
  logic [2:0] ill_f3[7] = '{3'b000, 3'b001, 3'b000, 3'b000, 3'b010, 3'b110, 3'b000};
  logic [6:0] ill_f7[7] = '{7'b0000001, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0100000, 7'b0000000};

  initial begin
    int rq, bad, cyc;
    clear_acc();
    repeat (3) @(negedge clk);
    check("reset_outputs", {mem_req, mem_we, addr_src, ir_we, pc_we, alu_src_a, alu_src_b,
                            alu_op, reg_write, wd_src, instr_done}, 0);
    check("reset_trap", {trap, trap_cause}, 0);

    add_instr(K_ADD, 0, 0, 1'b0);
    add_instr(K_LW,  0, 3, 1'b0);
    add_instr(K_BEQ, 0, 0, 1'b1);
    add_instr(K_BEQ, 0, 0, 1'b0);
    add_instr(K_BNE, 1, 0, 1'b0);
    add_instr(K_LUI, 3, 0, 1'b1);
    add_instr(K_SW,  2, 3, 1'b0);
    for (int i = 0; i < 40; i++)
      add_instr($urandom_range(0, 10), $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom_range(0, 1)));

    rst = 1'b0;
    #1;
    check("idle_after_release", {mem_req, ir_we, pc_we, trap}, 0);
    @(negedge clk);
    check("fetch_after_idle", {mem_req, addr_src, alu_src_a, alu_src_b, alu_op}, {1'b1, 1'b0, 2'd0, 2'd2, 3'd0});
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #2;
      if (exp_q.size() == 0) break;
    end
    check("pending_retires", exp_q.size(), 0);

    // Tail fetch is never acknowledged: bus timeout after TIMEOUT request cycles.
    rq = 0;
    for (int i = 0; i < 20 && !trap; i++) begin
      @(negedge clk);
      if (mem_req) rq++;
    end
    check("timeout_req_cycles", rq, 4);
    check("timeout_trap", {trap, trap_cause}, {1'b1, 1'b1});
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (!trap || !trap_cause || mem_req || ir_we || pc_we || reg_write || instr_done) bad++;
    end
    check("bus_trap_sticky", bad, 0);

    for (int k = 0; k < 7; k++) begin
      rst = 1'b1;
      @(negedge clk);
      exp_q.delete(); n_prog = 0;
      add_raw(ill_op[k], ill_f3[k], ill_f7[k], 0, 0, 1'b0);
      rst = 1'b0;
      for (cyc = 1; cyc <= 20; cyc++) begin
        @(negedge clk);
        if (trap) break;
      end
      check($sformatf("illegal_%0d_cycles", k), cyc, 3);
      check($sformatf("illegal_%0d_cause", k), {trap, trap_cause}, {1'b1, 1'b0});
      if (k == 0) begin
        bad = 0;
        repeat (100) begin
          @(negedge clk);
          if (!trap || trap_cause || mem_req || mem_we || ir_we || pc_we || reg_write || instr_done) bad++;
        end
        check("illegal_trap_sticky", bad, 0);
      end
    end

    rst = 1'b1;
    @(negedge clk);
    exp_q.delete(); n_prog = 0;
    add_raw(7'b0100011, 3'b010, 7'd0, 0, 3, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 20 && !addr_src; i++) @(negedge clk);
    @(negedge clk);
    check("sw_mem_phase", {mem_req, mem_we, addr_src}, 3'b111);
    rst = 1'b1;
    #1;
    check("reset_mid_mem", {mem_req, mem_we, addr_src}, 3'b000);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("idle_after_mid_reset", {mem_req, trap}, 2'b00);
    @(negedge clk);
    check("fetch_after_mid_reset", {mem_req, addr_src, mem_we}, 3'b100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control FSM for the RV32I-subset core. It sequences one shared ALU and a single-port instruction/data memory through fetch, decode, execute, memory and writeback. It decodes the latched instruction fields, drives every datapath mux and write enable, and traps on illegal opcodes or a memory that never acknowledges. It sits between the instruction register and the datapath, in place of a single-cycle decoder.

## Interface
- TIMEOUT, 16: cycles a memory request may wait for `mem_ack` before a bus trap (legal range 2..255).
- clk  in  1  core clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_op  in  7  opcode field from the instruction register.
- cmd_f3  in  3  funct3 field from the instruction register.
- cmd_f7  in  7  funct7 field from the instruction register.
- alu_zero  in  1  ALU result is zero.
- mem_ack  in  1  memory completed the current request this cycle.
- mem_req  out  1  memory request; held until acknowledged.
- mem_we  out  1  the request is a store.
- addr_src  out  1  memory address select: 0 = PC, 1 = ALU result register.
- ir_we  out  1  instruction register load.
- pc_we  out  1  PC load.
- alu_src_a  out  2  ALU operand A select: 0 = PC, 1 = old PC, 2 = rs1.
- alu_src_b  out  2  ALU operand B select: 0 = rs2, 1 = immediate, 2 = constant 4.
- alu_op  out  3  ALU operation: 000 add, 001 or, 010 srl, 011 sltu, 100 sub.
- reg_write  out  1  register file write enable.
- wd_src  out  2  register write-data select: 0 = ALU, 1 = memory data, 2 = U-immediate.
- instr_done  out  1  one-cycle pulse when an instruction retires.
- trap  out  1  sticky; the core is halted.
- trap_cause  out  1  0 = illegal instruction, 1 = bus timeout; valid only while `trap` = 1.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, BRANCH, TRAP.
- Reset: state = IDLE, timeout counter = 0, `trap` = 0, `trap_cause` = 0.
- IDLE: all outputs 0. Go to FETCH on the next cycle.
- FETCH:
  - Drives `mem_req` = 1, `addr_src` = 0, `alu_src_a` = 0, `alu_src_b` = 2, `alu_op` = add.
  - When `mem_ack` = 1: `ir_we` = 1 and `pc_we` = 1 in the same cycle (Mealy outputs), then go to DECODE.
- DECODE: classify the instruction; go to EXEC, or go to WB for lui.
  - R-type (op 0110011), valid {f7, f3} pairs only: add {0000000, 000}, or {0000000, 110}, srl {0000000, 101}, sltu {0000000, 011}, sub {0100000, 000}.
  - addi: op 0010011, f3 000. lui: op 0110111. lw: op 0000011, f3 010. sw: op 0100011, f3 010.
  - beq: op 1100011, f3 000. bne: op 1100011, f3 001.
  - Anything else is illegal: go to TRAP with cause 0.
- EXEC:
  - R-type: `alu_src_a` = 2, `alu_src_b` = 0, `alu_op` from the table; go to WB.
  - addi / lw / sw: `alu_src_a` = 2, `alu_src_b` = 1, `alu_op` = add. addi goes to WB; lw and sw go to MEM.
  - beq / bne: `alu_src_a` = 2, `alu_src_b` = 0, `alu_op` = sub.
    - Taken (beq with `alu_zero` = 1, or bne with `alu_zero` = 0): go to BRANCH.
    - Not taken: `instr_done` = 1, go to FETCH.
- MEM: `mem_req` = 1, `addr_src` = 1, `mem_we` = 1 for sw. On `mem_ack`, lw goes to WB; sw pulses `instr_done` and goes to FETCH.
- WB: `reg_write` = 1, `wd_src` = 0 (ALU), 1 (lw) or 2 (lui); `instr_done` = 1; go to FETCH.
- BRANCH: `alu_src_a` = 1, `alu_src_b` = 1, `alu_op` = add, `pc_we` = 1, `instr_done` = 1; go to FETCH.
- TRAP: every output 0 except `trap` = 1 and `trap_cause`. Only reset leaves TRAP.

## Timing
- Cycles per instruction with zero-wait memory (`mem_ack` in the first request cycle): lui 3, R-type/addi 4, sw 4, lw 5, branch not taken 3, branch taken 4. Each memory wait cycle adds 1.
- Handshake: `mem_req`, `mem_we` and `addr_src` stay stable from request assertion until the cycle `mem_ack` = 1 is sampled. `mem_ack` outside FETCH or MEM is ignored.
- Timeout:
  - The counter increments each cycle `mem_req` = 1 and `mem_ack` = 0, and clears on ack or on entry to FETCH/MEM.
  - If the counter reaches TIMEOUT−1 with no ack, go to TRAP with cause 1 on the next edge. Ack in that same cycle wins.
- Reset asserted mid-instruction: outputs drop to IDLE values asynchronously, and any pending request is abandoned.

## Structure
- Package `ctrl_pkg`: state enum, ALU op codes, opcode/funct constants, mux-select encodings, trap cause constants.
- Sub-module `ctrl_decode` (combinational), from op/f3/f7:
  - instruction class: R, I, U, LOAD, STORE, BRANCH, ILLEGAL;
  - `alu_op`;
  - branch polarity (taken when zero / when not zero).
- The FSM, timeout counter and trap register live in `multicycle_ctrl`.

## Test plan
- Zero-wait add x3,x1,x2 (op 0110011, f3 000, f7 0000000) → IDLE→FETCH→DECODE→EXEC→WB; `alu_op` = 000 in EXEC; `reg_write` and `instr_done` pulse together in the 4th cycle after IDLE.
- lw with `mem_ack` delayed 3 cycles in MEM → `mem_req` and `addr_src` = 1 held for 4 cycles; `wd_src` = 1 in WB; total 8 cycles from FETCH.
- beq with `alu_zero` = 1 → BRANCH with `pc_we` = 1, `alu_src_a` = 1; same instruction with `alu_zero` = 0 → FETCH right after EXEC, `instr_done` pulses in EXEC.
- Illegal R-type (f7 0000001, f3 000) → TRAP after DECODE, `trap` = 1, `trap_cause` = 0; stays trapped for 100 cycles while `mem_ack` toggles.
- TIMEOUT = 4, `mem_ack` held 0 in FETCH → TRAP with `trap_cause` = 1 after 4 request cycles; a second run with ack in the 4th cycle proceeds to DECODE.
- `rst` asserted mid-MEM of a sw → `mem_req` and `mem_we` fall to 0 before the next clock edge; after release, IDLE → FETCH.
